lc3_mem_access_unit: RTL and testbench

- Memory-access stage of the LC-3 datapath, directly downstream of the MAR mux.
- Holds the MAR and MDR registers and runs the req/ready handshake to the external memory.
- Returns the R (ready) flag that the control FSM waits on during memory states.
- MAR is loaded from the bus, which carries the MAR mux output when GateMARMUX is active.

---
 rtl/lc3_mem_pkg.sv | 15 +
 rtl/lc3_mem_access_unit.sv | 135 +++++++++++++
 tb/tb_lc3_mem_access_unit.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory-access stage.
package lc3_mem_pkg;

    localparam int LC3_WORD_W = 16;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lc3_mem_access_unit.sv
// LC-3 memory-access stage: MAR/MDR registers plus the req/ready handshake
// to external memory, returning the one-cycle R flag to the control FSM.
module lc3_mem_access_unit
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W         = LC3_WORD_W,
    parameter int DATA_W         = LC3_WORD_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_bus,
    input  logic              i_LD_MAR,
    input  logic              i_LD_MDR,
    input  logic              i_MIO_EN,
    input  logic              i_R_W,
    output logic [ADDR_W-1:0] o_MAR,
    output logic [DATA_W-1:0] o_MDR,
    output logic              o_R,
    output logic              o_err,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ready
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   mar_q, mar_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    cnt_inc;

    assign cnt_inc = cnt_q + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        if (i_LD_MAR) begin
            mar_d = i_bus[ADDR_W-1:0];
        end
        if (i_LD_MDR && !i_MIO_EN) begin
            mdr_d = i_bus;
        end

        unique case (state_q)
            IDLE: begin
                if (i_MIO_EN) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    we_d    = i_R_W;
                    addr_d  = mar_q;
                    wdata_d = mdr_q;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                if (i_mem_ready) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    // Read data beats a simultaneous bus load of the MDR.
                    if (we_q == RW_READ && i_LD_MDR) begin
                        mdr_d = i_mem_rdata;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_LIMIT) begin
                        state_d = DONE;
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        err_d   = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_MAR       = mar_q;
    assign o_MDR       = mdr_q;
    assign o_R         = (state_q == DONE);
    assign o_err       = err_q;
    assign o_mem_req   = req_q;
    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;

endmodule

// File: tb/tb_lc3_mem_access_unit.sv
// Scoreboard bench: stimulus queues expected access results, a monitor checks
// them on every R pulse, and a simple memory responder supplies ready/rdata.
module tb_lc3_mem_access_unit;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic [15:0] mdr;
        logic        err;
        int          req_cycles;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus;
    logic        ld_mar, ld_mdr, mio_en, r_w;
    logic [15:0] mar, mdr, mem_addr, mem_wdata, mem_rdata;
    logic        r, err, mem_req, mem_we, mem_ready;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int wait_states = 0;
    exp_t exp_q[$];
    logic [15:0] mem [logic [15:0]];

    always #5 clk = ~clk;

    lc3_mem_access_unit #(
        .ADDR_W(16), .DATA_W(16), .TIMEOUT_CYCLES(4)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_bus(bus),
        .i_LD_MAR(ld_mar), .i_LD_MDR(ld_mdr), .i_MIO_EN(mio_en), .i_R_W(r_w),
        .o_MAR(mar), .o_MDR(mdr), .o_R(r), .o_err(err),
        .o_mem_req(mem_req), .o_mem_we(mem_we),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_r(input string name);
        int n = 0;
        while (r !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, r}, 32'd1);
    endtask

    // Memory responder: raises ready after wait_states REQ cycles.
    initial begin
        int seen = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                if (seen == wait_states) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 16'hDEAD;
                end else begin
                    mem_ready = 1'b0;
                end
                seen++;
            end else begin
                mem_ready = 1'b0;
                seen = 0;
            end
        end
    end

    // Monitor: checks held request fields and each completion.
    initial begin
        int req_cnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                req_cnt++;
                if (exp_q.size() > 0) begin
                    chk("req_addr", {16'd0, mem_addr}, {16'd0, exp_q[0].addr});
                    chk("req_we", {31'd0, mem_we}, {31'd0, exp_q[0].we});
                    chk("req_wdata", {16'd0, mem_wdata}, {16'd0, exp_q[0].wdata});
                end
            end
            if (r === 1'b1) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_R", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    $display("access done addr=%h mdr=%h err=%b req_cycles=%0d",
                             mem_addr, mdr, err, req_cnt);
                    chk("done_addr", {16'd0, mem_addr}, {16'd0, e.addr});
                    chk("done_mdr", {16'd0, mdr}, {16'd0, e.mdr});
                    chk("done_err", {31'd0, err}, {31'd0, e.err});
                    chk("done_req_cycles", req_cnt, e.req_cycles);
                end
                req_cnt = 0;
            end else if (mem_req !== 1'b1) begin
                req_cnt = 0;
            end
        end
    end

    function automatic exp_t mk(input logic [15:0] a, input logic w, input logic [15:0] wd,
                                input logic [15:0] m, input logic er, input int rc);
        exp_t e;
        e.addr = a; e.we = w; e.wdata = wd; e.mdr = m; e.err = er; e.req_cycles = rc;
        return e;
    endfunction

    initial begin
        rst = 1'b1; bus = '0; ld_mar = 0; ld_mdr = 0; mio_en = 0; r_w = 0;
        mem[16'h3000] = 16'h1234;
        mem[16'h0005] = 16'h0055;
        mem[16'h0006] = 16'h0066;
        tick(3);
        rst = 1'b0;
        chk("rst_MAR", {16'd0, mar}, 32'd0);
        chk("rst_MDR", {16'd0, mdr}, 32'd0);
        chk("rst_R", {31'd0, r}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);

        // 1: zero-wait read at x3000, bus-load vs read data at completion edge
        wait_states = 0;
        bus = 16'h3000; ld_mar = 1; tick(1); ld_mar = 0;
        chk("t1_MAR", {16'd0, mar}, 32'h3000);
        exp_q.push_back(mk(16'h3000, 1'b0, 16'h0000, 16'h1234, 1'b0, 1));
        mio_en = 1; ld_mdr = 1; r_w = 0;
        tick(1);
        mio_en = 0;
        chk("t1_R_cycle2", {31'd0, r}, 32'd0);
        chk("t1_req_cycle2", {31'd0, mem_req}, 32'd1);
        tick(1);
        chk("t1_R_cycle3", {31'd0, r}, 32'd1);
        ld_mdr = 0;
        tick(1);
        chk("t1_R_after", {31'd0, r}, 32'd0);

        // 2: write with 3 wait states
        wait_states = 3;
        bus = 16'hBEEF; ld_mdr = 1; tick(1); ld_mdr = 0;
        bus = 16'hFE06; ld_mar = 1; tick(1); ld_mar = 0;
        exp_q.push_back(mk(16'hFE06, 1'b1, 16'hBEEF, 16'hBEEF, 1'b0, 4));
        mio_en = 1; r_w = 1;
        tick(1);
        mio_en = 0; r_w = 0;
        wait_r("t2_R");
        tick(1);
        chk("t2_MDR_kept", {16'd0, mdr}, 32'hBEEF);
        chk("t2_we_low", {31'd0, mem_we}, 32'd0);

        // 3: MAR load during in-flight read
        wait_states = 2;
        bus = 16'h3000; ld_mar = 1; tick(1); ld_mar = 0;
        exp_q.push_back(mk(16'h3000, 1'b0, 16'hBEEF, 16'h1234, 1'b0, 3));
        mio_en = 1; ld_mdr = 1;
        tick(1);
        mio_en = 0; ld_mdr = 0; bus = 16'h4000; ld_mar = 1;
        tick(1);
        ld_mar = 0;
        chk("t3_MAR_new", {16'd0, mar}, 32'h4000);
        chk("t3_addr_held", {16'd0, mem_addr}, 32'h3000);
        ld_mdr = 1;
        wait_r("t3_R");
        ld_mdr = 0;
        tick(1);

        // 4: timeout, ready never asserted
        wait_states = 99;
        exp_q.push_back(mk(16'h4000, 1'b0, 16'h1234, 16'h1234, 1'b1, 4));
        mio_en = 1; ld_mdr = 1;
        tick(1);
        wait_r("t4_R");
        mio_en = 0; ld_mdr = 0;
        tick(1);
        chk("t4_req_low", {31'd0, mem_req}, 32'd0);
        chk("t4_R_low", {31'd0, r}, 32'd0);
        tick(3);
        chk("t4_err_sticky", {31'd0, err}, 32'd1);

        // 5: reset in the middle of an access
        mio_en = 1;
        tick(1);
        mio_en = 0;
        chk("t5_req_before", {31'd0, mem_req}, 32'd1);
        rst = 1;
        tick(1);
        rst = 0;
        chk("t5_req", {31'd0, mem_req}, 32'd0);
        chk("t5_R", {31'd0, r}, 32'd0);
        chk("t5_MAR", {16'd0, mar}, 32'd0);
        chk("t5_MDR", {16'd0, mdr}, 32'd0);
        chk("t5_err", {31'd0, err}, 32'd0);

        // 6: back-to-back reads at x0005 and x0006
        wait_states = 0;
        bus = 16'h0005; ld_mar = 1; tick(1); ld_mar = 0;
        exp_q.push_back(mk(16'h0005, 1'b0, 16'h0000, 16'h0055, 1'b0, 1));
        exp_q.push_back(mk(16'h0006, 1'b0, 16'h0055, 16'h0066, 1'b0, 1));
        mio_en = 1; ld_mdr = 1;
        tick(1);
        bus = 16'h0006; ld_mar = 1;
        tick(1);
        ld_mar = 0;
        chk("t6_R1", {31'd0, r}, 32'd1);
        tick(1);
        chk("t6_idle_R", {31'd0, r}, 32'd0);
        chk("t6_idle_req", {31'd0, mem_req}, 32'd0);
        tick(1);
        chk("t6_req2", {31'd0, mem_req}, 32'd1);
        tick(1);
        chk("t6_R2", {31'd0, r}, 32'd1);
        mio_en = 0; ld_mdr = 0;
        tick(1);
        chk("t6_R_after", {31'd0, r}, 32'd0);
        tick(3);

        chk("queue_empty", exp_q.size(), 32'd0);
        chk("pulse_count", pulses, 32'd6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
